uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter between NREQ byte requesters using round-robin arbitration.
//  Drives tx_start/w_data into the uart top and sequences one byte at a time by waiting for
//  tx_done_tick. Supports burst lock, so one multi-byte message is not interleaved with others.
//  Has a watchdog that recovers if tx_done_tick never arrives. Sits between the application
//  sources and the uart instance.
// PARAMETERS
//  NREQ     4      number of requesters (2..8)
//  DBIT     8      data bits per byte; must match uart DBIT
//  TIMEOUT  65535  clk cycles allowed from tx_start to tx_done_tick (>= 10*16*DVSR = 52160)
// PORTS
//  clk           in   1          system clock
//  reset         in   1          asynchronous, active-low reset
//  req           in   NREQ       req[i]=1: requester i has a byte on req_data slice i
//  req_data      in   NREQ*DBIT  byte i is at [i*DBIT +: DBIT]; held stable while req[i]=1
//  req_last      in   NREQ       1 = this byte ends requester i's burst; 0 = lock grant to i
//  ack           out  NREQ       1-cycle pulse: byte of requester i accepted
//  grant_id      out  clog2 NREQ index of the requester currently/last served
//  busy          out  1          a byte is in flight (tx_start issued, done not yet seen)
//  tx_start      out  1          1-cycle start pulse to uart
//  w_data        out  DBIT       byte to uart; registered, held until next acceptance
//  tx_done_tick  in   1          uart transmit-complete pulse
//  timeout_err   out  1          1-cycle pulse: watchdog expired
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset: ack=0, grant_id=0, busy=0, tx_start=0, w_data=0, timeout_err=0, rr_ptr=0,
//   lock cleared, state=IDLE. The arbiter does not abort a frame already inside the uart.
//  FSM: IDLE -> SEND -> IDLE. All outputs are registered.
//  IDLE:
//   - If lock is valid and req[lock_id]=1, winner = lock_id.
//   - If lock is valid and req[lock_id]=0, clear the lock and arbitrate this same cycle.
//   - Otherwise winner = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NREQ.
//   - If there is any winner, next cycle: tx_start=1, ack[winner]=1, w_data=req_data[winner],
//     grant_id=winner, busy=1, wdog=0, state=SEND.
//   - Latency from req to tx_start/ack is 1 cycle. ack and tx_start coincide.
//   - tx_done_tick seen in IDLE is ignored.
//  SEND:
//   - wdog increments every cycle. Other req changes are ignored.
//   - On tx_done_tick: busy=0, rr_ptr=(grant_id+1) mod NREQ.
//     lock = ~req_last of the sampled winner, lock_id=grant_id. Go to IDLE.
//   - If wdog==TIMEOUT-1 and no tx_done_tick: timeout_err=1, busy=0, lock cleared,
//     rr_ptr advanced as above, go to IDLE.
//   - tx_done_tick in the same cycle as expiry: done wins, no timeout_err.
//  Throughput: minimum 2 cycles from tx_done_tick to the next tx_start (done->IDLE, IDLE->start).
//  Requester rules: keep req[i] high until ack[i]. Dropping req before ack withdraws the byte.
//   After ack, req[i] may stay high with the next byte, which is accepted in a later IDLE.
//  req_last is sampled with the winner's data in IDLE.
//  wdog width = clog2(TIMEOUT+1). No wrap: it is cleared on every acceptance.
// STRUCTURE
//  uart_pkg: state encoding (IDLE, SEND), UART_DBIT=8, default TIMEOUT constant.
//  Sub-module rr_pick: combinational round-robin picker.
//   Inputs: req[NREQ], ptr. Outputs: valid, idx. Rotate, priority-encode, un-rotate.
//  Top: FSM, data/lock/ptr registers, watchdog counter.
// TESTING
//  1 Reset: hold reset=0 with req=4'b1111 -> all outputs 0. Release -> first tx_start
//    1 cycle later, grant_id=0, w_data=req_data[7:0].
//  2 Round-robin: req=4'b1111, all req_last=1, done 20 cycles after each start
//    -> grant order 0,1,2,3,0; exactly one ack per start.
//  3 Burst lock: req0 sends 3 bytes (last=0,0,1) while req2 is asserted
//    -> bytes 0,0,0 then requester 2. If req0 drops mid-burst, the lock releases and 2 wins.
//  4 Watchdog: TIMEOUT=100, never pulse done -> timeout_err exactly 100 cycles after
//    tx_start, busy=0, next request served normally.
//  5 Edge: done and expiry in the same cycle -> no timeout_err. Stray done in IDLE -> no effect.
//  6 Async reset mid-SEND -> outputs clear immediately. After release, rr_ptr=0 and
//    no stale ack is issued.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants and state encoding for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

    localparam int UART_DBIT   = 8;
    localparam int DEF_NREQ    = 4;
    localparam int DEF_TIMEOUT = 65535;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests so ptr is bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            valid,
    output logic [IDW-1:0]  idx
);

    logic [NREQ-1:0] rot;
    logic [IDW-1:0]  off;

    always_comb begin
        rot = '0;
        for (int k = 0; k < NREQ; k++) begin
            rot[k] = req[IDW'((int'(ptr) + k) % NREQ)];
        end
    end

    // Descending scan so the lowest rotated position wins.
    always_comb begin
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) off = IDW'(k);
        end
    end

    assign valid = |rot;
    assign idx   = IDW'((int'(off) + int'(ptr)) % NREQ);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter, with burst lock and a
// watchdog that recovers when tx_done_tick never arrives.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int NREQ    = DEF_NREQ,
    parameter  int DBIT    = UART_DBIT,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DBIT-1:0] req_data,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      ack,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy,
    output logic                 tx_start,
    output logic [DBIT-1:0]      w_data,
    input  logic                 tx_done_tick,
    output logic                 timeout_err
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    arb_state_e state_q, state_d;

    logic [NREQ-1:0] ack_q, ack_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  lock_id_q, lock_id_d;
    logic            lock_valid_q, lock_valid_d;
    logic            last_q, last_d;
    logic            busy_q, busy_d;
    logic            tx_start_q, tx_start_d;
    logic            timeout_err_q, timeout_err_d;
    logic [DBIT-1:0] w_data_q, w_data_d;
    logic [WDW-1:0]  wdog_q, wdog_d;

    logic [NREQ-1:0][DBIT-1:0] data_arr;
    logic                      pick_valid;
    logic [IDW-1:0]            pick_idx;
    logic                      lock_hit;
    logic                      win_valid;
    logic [IDW-1:0]            win_idx;
    logic [IDW-1:0]            next_ptr;

    assign data_arr = req_data;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // A held lock overrides round-robin only while its owner keeps requesting.
    assign lock_hit  = lock_valid_q && req[lock_id_q];
    assign win_valid = lock_hit || pick_valid;
    assign win_idx   = lock_hit ? lock_id_q : pick_idx;
    assign next_ptr  = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + IDW'(1);

    always_comb begin
        state_d       = state_q;
        ack_d         = '0;
        tx_start_d    = 1'b0;
        timeout_err_d = 1'b0;
        grant_id_d    = grant_id_q;
        rr_ptr_d      = rr_ptr_q;
        lock_id_d     = lock_id_q;
        lock_valid_d  = lock_valid_q;
        last_d        = last_q;
        busy_d        = busy_q;
        w_data_d      = w_data_q;
        wdog_d        = wdog_q;

        case (state_q)
            IDLE: begin
                if (lock_valid_q && !lock_hit) lock_valid_d = 1'b0;
                if (win_valid) begin
                    tx_start_d       = 1'b1;
                    ack_d[win_idx]   = 1'b1;
                    w_data_d         = data_arr[win_idx];
                    grant_id_d       = win_idx;
                    last_d           = req_last[win_idx];
                    busy_d           = 1'b1;
                    wdog_d           = '0;
                    state_d          = SEND;
                end
            end
            SEND: begin
                wdog_d = wdog_q + WDW'(1);
                // Done takes priority over a watchdog expiry in the same cycle.
                if (tx_done_tick) begin
                    busy_d       = 1'b0;
                    rr_ptr_d     = next_ptr;
                    lock_valid_d = ~last_q;
                    lock_id_d    = grant_id_q;
                    state_d      = IDLE;
                end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    busy_d        = 1'b0;
                    rr_ptr_d      = next_ptr;
                    lock_valid_d  = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            ack_q         <= '0;
            tx_start_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            grant_id_q    <= '0;
            rr_ptr_q      <= '0;
            lock_id_q     <= '0;
            lock_valid_q  <= 1'b0;
            last_q        <= 1'b0;
            busy_q        <= 1'b0;
            w_data_q      <= '0;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            ack_q         <= ack_d;
            tx_start_q    <= tx_start_d;
            timeout_err_q <= timeout_err_d;
            grant_id_q    <= grant_id_d;
            rr_ptr_q      <= rr_ptr_d;
            lock_id_q     <= lock_id_d;
            lock_valid_q  <= lock_valid_d;
            last_q        <= last_d;
            busy_q        <= busy_d;
            w_data_q      <= w_data_d;
            wdog_q        <= wdog_d;
        end
    end

    assign ack         = ack_q;
    assign tx_start    = tx_start_q;
    assign timeout_err = timeout_err_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
    assign w_data      = w_data_q;

endmodule
